// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared types and sizing helpers for the multi-cycle adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } adder_state_e;

    function automatic int unsigned calc_nchunk(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

    // A one-chunk build still needs a 1-bit index so the counter has a width.
    function automatic int unsigned calc_idx_w(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_chunk.sv
// ============================================================================
// Module      : adder_chunk
// Description : Purely combinational CHUNK-bit adder with carry in and out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_chunk #(
    parameter int unsigned CHUNK = 32
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             c
);

    assign {c, s} = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);

endmodule

`default_nettype wire

// File: rtl/multi_cycle_adder.sv
// ============================================================================
// Module      : multi_cycle_adder
// Description : Computes {cout,sum} = a + b + cin one CHUNK slice per clock
//               behind valid/ready handshakes. Define MULTI_CYCLE_ADDER_SUB_EN
//               to add the 'sub' port (b stored inverted on accept).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MULTI_CYCLE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned              c_nchunk   = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned              c_idx_w    = calc_idx_w(c_nchunk);
    localparam logic [c_idx_w-1:0]       c_last_idx = c_idx_w'(c_nchunk - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("multi_cycle_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    adder_state_e       state_q, state_d;
    logic [c_idx_w-1:0] idx_q,   idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;

    logic               w_accept;
    logic [CHUNK-1:0]   w_chunk_a;
    logic [CHUNK-1:0]   w_chunk_b;
    logic [CHUNK-1:0]   w_chunk_s;
    logic               w_chunk_c;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign w_accept  = in_valid && in_ready;

    // One shared adder; the index selects which slice it sees each cycle.
    assign w_chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign w_chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a   (w_chunk_a),
        .b   (w_chunk_b),
        .cin (carry_q),
        .s   (w_chunk_s),
        .c   (w_chunk_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        if (w_accept) begin
            a_d     = a;
`ifdef MULTI_CYCLE_ADDER_SUB_EN
            b_d     = sub ? ~b : b;
`else
            b_d     = b;
`endif
            carry_d = cin;
            idx_d   = '0;
            state_d = BUSY;
        end else begin
            case (state_q)
                BUSY: begin
                    sum_d[idx_q*CHUNK +: CHUNK] = w_chunk_s;
                    carry_d = w_chunk_c;
                    if (idx_q == c_last_idx) begin
                        cout_d  = w_chunk_c;
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + c_idx_w'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

`default_nettype wire
